// File: rtl/mac_ctrl.sv
// Controller that loads three weights into a MAC, streams feature windows through it
// and returns each captured result over a valid/ready handshake.
module mac_ctrl #(
    parameter int DATA_BIT = 16,
    parameter int MAC_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_BIT-1:0]   w_data,
    input  logic                  f_valid,
    output logic                  f_ready,
    input  logic [DATA_BIT-1:0]   f_data,
    input  logic                  reconf,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*DATA_BIT+1:0] res_data,
    output logic                  mac_clear,
    output logic                  mac_w_w,
    output logic [DATA_BIT-1:0]   mac_w_in,
    output logic                  mac_if_w,
    output logic [DATA_BIT-1:0]   mac_if_in,
    input  logic [2*DATA_BIT+1:0] mac_out,
    output logic                  busy
);

    localparam int RES_W = 2 * DATA_BIT + 2;
    localparam int LAT_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        PUSH_W,
        LOAD_F,
        WAIT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           w_cnt_q, w_cnt_d;
    logic [1:0]           f_cnt_q, f_cnt_d;
    logic [1:0]           p_cnt_q, p_cnt_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [DATA_BIT-1:0]  shadow_q [3];
    logic [DATA_BIT-1:0]  shadow_d [3];
    logic                 res_valid_q, res_valid_d;
    logic [RES_W-1:0]     res_data_q, res_data_d;
    logic                 mac_clear_q, mac_clear_d;
    logic                 mac_w_w_q, mac_w_w_d;
    logic [DATA_BIT-1:0]  mac_w_in_q, mac_w_in_d;
    logic                 mac_if_w_q, mac_if_w_d;
    logic [DATA_BIT-1:0]  mac_if_in_q, mac_if_in_d;

    logic w_acc;
    logic f_acc;

    // Ready terms are gated by rst so nothing is offered while reset is held.
    assign w_ready = (state_q == IDLE) && !rst;
    assign f_ready = (state_q == LOAD_F) && !rst;
    assign busy    = (state_q != IDLE);
    assign w_acc   = w_valid && w_ready;
    assign f_acc   = f_valid && f_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        f_cnt_d     = f_cnt_q;
        p_cnt_d     = p_cnt_q;
        lat_d       = lat_q;
        shadow_d    = shadow_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        mac_clear_d = 1'b0;
        mac_w_w_d   = 1'b0;
        mac_w_in_d  = '0;
        mac_if_w_d  = 1'b0;
        mac_if_in_d = '0;

        unique case (state_q)
            IDLE: begin
                if (w_acc) begin
                    shadow_d[w_cnt_q] = w_data;
                    if (w_cnt_q == 2'd2) begin
                        w_cnt_d     = '0;
                        state_d     = CLR;
                        mac_clear_d = 1'b1;
                    end else begin
                        w_cnt_d = w_cnt_q + 2'd1;
                    end
                end
            end
            CLR: begin
                // p_cnt holds the index of the weight to present in the next cycle.
                state_d    = PUSH_W;
                p_cnt_d    = 2'd1;
                mac_w_w_d  = 1'b1;
                mac_w_in_d = shadow_q[0];
            end
            PUSH_W: begin
                if (p_cnt_q == 2'd3) begin
                    p_cnt_d = '0;
                    state_d = LOAD_F;
                end else begin
                    mac_w_w_d  = 1'b1;
                    mac_w_in_d = shadow_q[p_cnt_q];
                    p_cnt_d    = p_cnt_q + 2'd1;
                end
            end
            LOAD_F: begin
                if (f_acc) begin
                    mac_if_w_d  = 1'b1;
                    mac_if_in_d = f_data;
                    if (f_cnt_q == 2'd2) begin
                        f_cnt_d = '0;
                        lat_d   = '0;
                        state_d = WAIT;
                    end else begin
                        f_cnt_d = f_cnt_q + 2'd1;
                    end
                end
            end
            WAIT: begin
                if (lat_q == LAT_W'(MAC_LAT)) begin
                    lat_d       = '0;
                    res_data_d  = mac_out;
                    res_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (reconf) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = CLR;
                        mac_clear_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            w_cnt_q     <= '0;
            f_cnt_q     <= '0;
            p_cnt_q     <= '0;
            lat_q       <= '0;
            // NOTE: the three-entry shadow file is plain flops, so clearing it on reset is cheap and expected.
            shadow_q    <= '{default: '0};
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            mac_clear_q <= 1'b0;
            mac_w_w_q   <= 1'b0;
            mac_w_in_q  <= '0;
            mac_if_w_q  <= 1'b0;
            mac_if_in_q <= '0;
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            f_cnt_q     <= f_cnt_d;
            p_cnt_q     <= p_cnt_d;
            lat_q       <= lat_d;
            shadow_q    <= shadow_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            mac_clear_q <= mac_clear_d;
            mac_w_w_q   <= mac_w_w_d;
            mac_w_in_q  <= mac_w_in_d;
            mac_if_w_q  <= mac_if_w_d;
            mac_if_in_q <= mac_if_in_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign mac_clear = mac_clear_q;
    assign mac_w_w   = mac_w_w_q;
    assign mac_w_in  = mac_w_in_q;
    assign mac_if_w  = mac_if_w_q;
    assign mac_if_in = mac_if_in_q;

endmodule
